mii_rx_nibble_assembler: RTL and testbench

- Sits directly downstream of the source-synchronous SDR input stage on a 10/100 MII receive path.
- Runs in that stage's recovered receive clock and consumes its registered rxd/rx_dv/rx_er nibbles.
- Detects preamble/SFD, locks byte alignment on the SFD and assembles nibble pairs into GMII-style bytes with a byte-valid strobe.
- Polices malformed frames (bad preamble, odd nibble count, oversize) and emits per-frame status pulses for the MAC receive logic.

---
 rtl/mii_rx_nibble_assembler_pkg.sv | 24 ++
 rtl/mii_rx_nibble_assembler.sv | 202 ++++++++++++++++++++
 tb/tb_mii_rx_nibble_assembler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_rx_nibble_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mii_rx_nibble_assembler_pkg
// Brief   : Shared MII/GMII constants and FSM state encodings for the
//           receive nibble assembler.
// Revision: 1.0 - initial release
// ============================================================================
package mii_rx_nibble_assembler_pkg;

    localparam logic [3:0] MII_PRE_NIBBLE = 4'h5;
    localparam logic [3:0] MII_SFD_NIBBLE = 4'hD;
    localparam logic [7:0] GMII_SFD_BYTE  = 8'hD5;

    localparam int         STATE_W        = 2;
    localparam logic [1:0] ST_WAIT_IDLE   = 2'd0;
    localparam logic [1:0] ST_IDLE        = 2'd1;
    localparam logic [1:0] ST_PREAMBLE    = 2'd2;
    localparam logic [1:0] ST_DATA        = 2'd3;

    localparam logic       PHASE_LOW      = 1'b0;
    localparam logic       PHASE_HIGH     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mii_rx_nibble_assembler.sv
`default_nettype none
// ============================================================================
// Module  : mii_rx_nibble_assembler
// Brief   : Locks byte alignment on the MII SFD, pairs nibbles into GMII-style
//           bytes and flags bad preamble, dribble and oversize frames.
// Revision: 1.0 - initial release
// ============================================================================
module mii_rx_nibble_assembler
    import mii_rx_nibble_assembler_pkg::*;
#(
    parameter int MAX_BYTES = 1518,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           mii_rxd,
    input  logic                 mii_rx_dv,
    input  logic                 mii_rx_er,
    output logic [7:0]           gmii_rxd,
    output logic                 gmii_rx_dv,
    output logic                 gmii_rx_er,
    output logic                 gmii_rx_valid,
    output logic                 stat_sfd,
    output logic                 stat_frame_done,
    output logic [LEN_WIDTH-1:0] stat_frame_len,
    output logic                 stat_bad_preamble,
    output logic                 stat_dribble,
    output logic                 stat_oversize
);

    localparam logic [LEN_WIDTH-1:0] c_max_bytes = LEN_WIDTH'(MAX_BYTES);
    localparam logic [LEN_WIDTH-1:0] c_len_ones  = '1;

    logic [STATE_W-1:0]   r_state;
    logic [3:0]           r_pre_cnt;
    logic                 r_phase;
    logic [3:0]           r_hold_nib;
    logic                 r_hold_er;
    logic [LEN_WIDTH-1:0] r_byte_cnt;
    logic                 r_oversize;
    logic                 r_term_pending;

    logic [7:0]           r_gmii_rxd;
    logic                 r_gmii_rx_dv;
    logic                 r_gmii_rx_er;
    logic                 r_gmii_rx_valid;
    logic                 r_stat_sfd;
    logic                 r_stat_frame_done;
    logic [LEN_WIDTH-1:0] r_stat_frame_len;
    logic                 r_stat_bad_preamble;
    logic                 r_stat_dribble;
    logic                 r_stat_oversize;

    logic [LEN_WIDTH-1:0] w_cnt_inc;
    logic                 w_over_now;
    logic                 w_over;

    // Byte count saturates; once a frame goes oversize it stays flagged.
    assign w_cnt_inc  = (r_byte_cnt == c_len_ones) ? r_byte_cnt : r_byte_cnt + 1'b1;
    assign w_over_now = (w_cnt_inc > c_max_bytes);
    assign w_over     = r_oversize | w_over_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= ST_WAIT_IDLE;
            r_pre_cnt           <= '0;
            r_phase             <= PHASE_LOW;
            r_hold_nib          <= '0;
            r_hold_er           <= 1'b0;
            r_byte_cnt          <= '0;
            r_oversize          <= 1'b0;
            r_term_pending      <= 1'b0;
            r_gmii_rxd          <= '0;
            r_gmii_rx_dv        <= 1'b0;
            r_gmii_rx_er        <= 1'b0;
            r_gmii_rx_valid     <= 1'b0;
            r_stat_sfd          <= 1'b0;
            r_stat_frame_done   <= 1'b0;
            r_stat_frame_len    <= '0;
            r_stat_bad_preamble <= 1'b0;
            r_stat_dribble      <= 1'b0;
            r_stat_oversize     <= 1'b0;
        end else begin
            r_gmii_rx_valid     <= 1'b0;
            r_stat_sfd          <= 1'b0;
            r_stat_frame_done   <= 1'b0;
            r_stat_bad_preamble <= 1'b0;
            r_stat_dribble      <= 1'b0;
            r_stat_oversize     <= 1'b0;

            case (r_state)
                ST_WAIT_IDLE: begin
                    if (!mii_rx_dv) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (mii_rx_dv) begin
                        if (!mii_rx_er && mii_rxd == MII_PRE_NIBBLE) begin
                            r_state   <= ST_PREAMBLE;
                            r_pre_cnt <= 4'd1;
                        end else begin
                            r_state             <= ST_WAIT_IDLE;
                            r_stat_bad_preamble <= 1'b1;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (!mii_rx_dv) begin
                        r_state <= ST_IDLE;
                    end else if (!mii_rx_er && mii_rxd == MII_PRE_NIBBLE) begin
                        if (r_pre_cnt != 4'hF) begin
                            r_pre_cnt <= r_pre_cnt + 4'd1;
                        end
                    end else if (!mii_rx_er && mii_rxd == MII_SFD_NIBBLE && r_pre_cnt != 4'd0) begin
                        r_gmii_rxd      <= GMII_SFD_BYTE;
                        r_gmii_rx_dv    <= 1'b1;
                        r_gmii_rx_er    <= 1'b0;
                        r_gmii_rx_valid <= 1'b1;
                        r_stat_sfd      <= 1'b1;
                        r_byte_cnt      <= '0;
                        r_oversize      <= 1'b0;
                        r_term_pending  <= 1'b0;
                        r_phase         <= PHASE_LOW;
                        r_state         <= ST_DATA;
                    end else begin
                        r_stat_bad_preamble <= 1'b1;
                        r_state             <= ST_WAIT_IDLE;
                    end
                end

                ST_DATA: begin
                    if (r_term_pending) begin
                        // Second beat after a dribble: a new dv here is mid-frame, so resync.
                        r_gmii_rxd        <= '0;
                        r_gmii_rx_dv      <= 1'b0;
                        r_gmii_rx_er      <= 1'b0;
                        r_gmii_rx_valid   <= 1'b1;
                        r_stat_frame_done <= 1'b1;
                        r_stat_frame_len  <= r_byte_cnt;
                        r_term_pending    <= 1'b0;
                        r_state           <= mii_rx_dv ? ST_WAIT_IDLE : ST_IDLE;
                    end else if (mii_rx_dv) begin
                        if (r_phase == PHASE_LOW) begin
                            r_hold_nib <= mii_rxd;
                            r_hold_er  <= mii_rx_er;
                            r_phase    <= PHASE_HIGH;
                        end else begin
                            r_gmii_rxd      <= {mii_rxd, r_hold_nib};
                            r_gmii_rx_dv    <= 1'b1;
                            r_gmii_rx_er    <= r_hold_er | mii_rx_er | w_over;
                            r_gmii_rx_valid <= 1'b1;
                            r_byte_cnt      <= w_cnt_inc;
                            r_oversize      <= w_over;
                            r_stat_oversize <= w_over_now & ~r_oversize;
                            r_phase         <= PHASE_LOW;
                        end
                    end else if (r_phase == PHASE_LOW) begin
                        r_gmii_rxd        <= '0;
                        r_gmii_rx_dv      <= 1'b0;
                        r_gmii_rx_er      <= 1'b0;
                        r_gmii_rx_valid   <= 1'b1;
                        r_stat_frame_done <= 1'b1;
                        r_stat_frame_len  <= r_byte_cnt;
                        r_state           <= ST_IDLE;
                    end else begin
                        // Carrier dropped with half a byte held: emit it as an errored byte.
                        r_gmii_rxd      <= {4'h0, r_hold_nib};
                        r_gmii_rx_dv    <= 1'b1;
                        r_gmii_rx_er    <= 1'b1;
                        r_gmii_rx_valid <= 1'b1;
                        r_stat_dribble  <= 1'b1;
                        r_byte_cnt      <= w_cnt_inc;
                        r_oversize      <= w_over;
                        r_stat_oversize <= w_over_now & ~r_oversize;
                        r_phase         <= PHASE_LOW;
                        r_term_pending  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    assign gmii_rxd          = r_gmii_rxd;
    assign gmii_rx_dv        = r_gmii_rx_dv;
    assign gmii_rx_er        = r_gmii_rx_er;
    assign gmii_rx_valid     = r_gmii_rx_valid;
    assign stat_sfd          = r_stat_sfd;
    assign stat_frame_done   = r_stat_frame_done;
    assign stat_frame_len    = r_stat_frame_len;
    assign stat_bad_preamble = r_stat_bad_preamble;
    assign stat_dribble      = r_stat_dribble;
    assign stat_oversize     = r_stat_oversize;

endmodule
`default_nettype wire

// File: tb/tb_mii_rx_nibble_assembler.sv
`default_nettype none
// ============================================================================
// Module  : tb_mii_rx_nibble_assembler
// Brief   : Directed frames against a frame-level expected-beat model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mii_rx_nibble_assembler;

    localparam int MAXB = 4;
    localparam int LW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    mii_rxd = 4'h0;
    logic          mii_rx_dv = 1'b0;
    logic          mii_rx_er = 1'b0;
    logic [7:0]    gmii_rxd;
    logic          gmii_rx_dv, gmii_rx_er, gmii_rx_valid;
    logic          stat_sfd, stat_frame_done, stat_bad_preamble, stat_dribble, stat_oversize;
    logic [LW-1:0] stat_frame_len;

    mii_rx_nibble_assembler #(.MAX_BYTES(MAXB), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .gmii_rx_valid(gmii_rx_valid), .stat_sfd(stat_sfd),
        .stat_frame_done(stat_frame_done), .stat_frame_len(stat_frame_len),
        .stat_bad_preamble(stat_bad_preamble), .stat_dribble(stat_dribble),
        .stat_oversize(stat_oversize)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    rxd;
        logic          dv, er, sfd, done, drib, ov;
        logic [LW-1:0] len;
    } beat_t;

    beat_t         exp_q[$];
    int            checks = 0, errors = 0;
    int            exp_bad = 0, obs_bad = 0, obs_ov = 0;
    logic [LW-1:0] model_len = '0;
    logic [7:0]    last_rxd = '0;
    logic          last_dv = 1'b0, last_er = 1'b0;
    logic          rst_q = 1'b1;
    logic [7:0]    obs_b[$];
    logic          obs_e[$];
    logic [3:0]    fn[$];
    logic          fe[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rst_q <= rst;

    // One compare process: every valid strobe consumes one expected beat, idle cycles must hold.
    always @(negedge clk) begin
        beat_t a, e;
        if (rst_q) begin
            model_len = '0;
            last_rxd  = '0;
            last_dv   = 1'b0;
            last_er   = 1'b0;
        end else begin
            a = '0;
            a.rxd = gmii_rxd; a.dv = gmii_rx_dv; a.er = gmii_rx_er;
            a.sfd = stat_sfd; a.done = stat_frame_done; a.drib = stat_dribble;
            a.ov = stat_oversize; a.len = stat_frame_len;
            if (stat_bad_preamble) obs_bad++;
            if (gmii_rx_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected no strobe", a);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.done) e.len = model_len;
                    check("beat", 64'(a), 64'(e));
                    if (e.done) model_len = e.len;
                    last_rxd = e.rxd; last_dv = e.dv; last_er = e.er;
                    if (gmii_rx_dv) begin
                        obs_b.push_back(gmii_rxd);
                        obs_e.push_back(gmii_rx_er);
                    end
                    if (stat_oversize) obs_ov++;
                end
            end else begin
                check("idle_hold", 64'({gmii_rxd, gmii_rx_dv, gmii_rx_er, stat_sfd, stat_frame_done,
                                        stat_dribble, stat_oversize, stat_frame_len}),
                      64'({last_rxd, last_dv, last_er, 4'b0000, model_len}));
            end
        end
    end

    task automatic push_beat(input logic [7:0] rxd, input logic dv, input logic er,
                             input logic sfd, input logic done, input logic drib,
                             input logic ov, input logic [LW-1:0] len);
        beat_t b;
        b = '0;
        b.rxd = rxd; b.dv = dv; b.er = er; b.sfd = sfd;
        b.done = done; b.drib = drib; b.ov = ov; b.len = len;
        exp_q.push_back(b);
    endtask

    // Frame-level model: walk the nibble list as a receiver would and list the beats it owes.
    task automatic model(input bit aborted);
        int i, cnt;
        bit over, ov_now;
        if (fn.size() == 0) return;
        if (fe[0] || fn[0] != 4'h5) begin exp_bad++; return; end
        i = 1;
        while (i < fn.size() && !fe[i] && fn[i] == 4'h5) i++;
        if (i >= fn.size()) return;
        if (fe[i] || fn[i] != 4'hD) begin exp_bad++; return; end
        push_beat(8'hD5, 1, 0, 1, 0, 0, 0, '0);
        i++; cnt = 0; over = 0;
        while (i + 1 < fn.size()) begin
            cnt++;
            ov_now = (cnt > MAXB) && !over;
            over   = over || (cnt > MAXB);
            push_beat({fn[i+1], fn[i]}, 1, fe[i] | fe[i+1] | over, 0, 0, 0, ov_now, '0);
            i += 2;
        end
        if (aborted) return;
        if (i < fn.size()) begin
            cnt++;
            ov_now = (cnt > MAXB) && !over;
            push_beat({4'h0, fn[i]}, 1, 1, 0, 0, 1, ov_now, '0);
        end
        push_beat(8'h00, 0, 0, 0, 1, 0, 0, LW'(cnt));
    endtask

    task automatic drive(input logic dv, input logic er, input logic [3:0] d);
        mii_rx_dv = dv; mii_rx_er = er; mii_rxd = d;
        @(negedge clk);
    endtask

    task automatic new_frame();
        fn.delete(); fe.delete();
        repeat (15) begin fn.push_back(4'h5); fe.push_back(1'b0); end
        fn.push_back(4'hD); fe.push_back(1'b0);
    endtask

    task automatic add_byte(input logic [7:0] b, input logic er_hi);
        fn.push_back(b[3:0]); fe.push_back(1'b0);
        fn.push_back(b[7:4]); fe.push_back(er_hi);
    endtask

    task automatic run(input string tag);
        model(1'b0);
        foreach (fn[k]) drive(1'b1, fe[k], fn[k]);
        repeat (5) drive(1'b0, 1'b0, 4'h0);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_bad_preamble"}, 64'(obs_bad), 64'(exp_bad));
    endtask

    initial begin
        int b0, ov0, bad0;
        logic [3:0] bad_nibs [8];
        bad_nibs = '{4'h5, 4'h5, 4'h7, 4'h5, 4'h5, 4'hD, 4'h1, 4'h0};

        repeat (3) @(negedge clk);
        check("reset_state", 64'({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, stat_sfd,
                                  stat_frame_done, stat_frame_len, stat_bad_preamble,
                                  stat_dribble, stat_oversize}), 64'd0);
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 4'h0);

        // Clean frame D5 01 02 03.
        b0 = obs_b.size();
        new_frame(); add_byte(8'h01, 0); add_byte(8'h02, 0); add_byte(8'h03, 0);
        run("basic");
        check("basic_bytes", 64'({obs_b[b0], obs_b[b0+1], obs_b[b0+2], obs_b[b0+3]}), 64'h00000000D5010203);
        check("basic_er", 64'({obs_e[b0], obs_e[b0+1], obs_e[b0+2], obs_e[b0+3]}), 64'd0);
        check("basic_len", 64'(stat_frame_len), 64'd3);

        // Receive error on the high nibble of byte 0x02.
        b0 = obs_b.size();
        new_frame(); add_byte(8'h01, 0); add_byte(8'h02, 1); add_byte(8'h03, 0);
        run("rx_er");
        check("rx_er_flags", 64'({obs_e[b0], obs_e[b0+1], obs_e[b0+2], obs_e[b0+3]}), 64'b0010);
        check("rx_er_len", 64'(stat_frame_len), 64'd3);

        // Dribble: only the low nibble of a 4th byte arrives.
        b0 = obs_b.size();
        new_frame(); add_byte(8'h01, 0); add_byte(8'h02, 0); add_byte(8'h03, 0);
        fn.push_back(4'h1); fe.push_back(1'b0);
        run("dribble");
        check("dribble_byte", 64'({obs_b[b0+4], 7'd0, obs_e[b0+4]}), 64'h0101);
        check("dribble_len", 64'(stat_frame_len), 64'd4);

        // Bad preamble mid-stream, then a frame whose first nibble is wrong.
        b0 = obs_b.size(); bad0 = obs_bad;
        fn.delete(); fe.delete();
        foreach (bad_nibs[k]) begin fn.push_back(bad_nibs[k]); fe.push_back(1'b0); end
        run("bad_pre");
        fn.delete(); fe.delete();
        fn.push_back(4'h8); fe.push_back(1'b0);
        repeat (3) begin fn.push_back(4'h5); fe.push_back(1'b0); end
        fn.push_back(4'hD); fe.push_back(1'b0);
        run("bad_first");
        check("bad_pre_count", 64'(obs_bad - bad0), 64'd2);
        check("bad_pre_no_bytes", 64'(obs_b.size() - b0), 64'd0);

        // Oversize with MAX_BYTES=4 and six payload bytes.
        b0 = obs_b.size(); ov0 = obs_ov;
        new_frame();
        for (int k = 1; k <= 6; k++) add_byte(8'(8'h10 + k), 0);
        run("oversize");
        check("oversize_er", 64'({obs_e[b0+4], obs_e[b0+5], obs_e[b0+6]}), 64'b011);
        check("oversize_pulses", 64'(obs_ov - ov0), 64'd1);
        check("oversize_len", 64'(stat_frame_len), 64'd6);

        // Reset mid-payload, released while dv is still high.
        new_frame(); add_byte(8'h01, 0); add_byte(8'h02, 0);
        model(1'b1);
        foreach (fn[k]) drive(1'b1, fe[k], fn[k]);
        mii_rx_dv = 1'b1; mii_rxd = 4'h3; rst = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", 64'({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, stat_sfd,
                                        stat_frame_done, stat_frame_len, stat_bad_preamble,
                                        stat_dribble, stat_oversize}), 64'd0);
        check("reset_mid_drained", 64'(exp_q.size()), 64'd0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h0);
        repeat (3) drive(1'b0, 1'b0, 4'h0);
        check("reset_ignored_tail", 64'(exp_q.size()), 64'd0);
        b0 = obs_b.size();
        new_frame(); add_byte(8'hA1, 0); add_byte(8'hB2, 0); add_byte(8'hC3, 0);
        run("after_reset");
        check("after_reset_bytes", 64'({obs_b[b0], obs_b[b0+1], obs_b[b0+2], obs_b[b0+3]}), 64'h00000000D5A1B2C3);
        check("after_reset_len", 64'(stat_frame_len), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
